// File: rtl/shadow_reset_reg.sv
// ---------------------------------------------------------------------------
// shadow_reset_reg
//
// WIDTH-bit control register with a shadow copy. Bus writes land in the
// shadow (with byte strobes and write/set/clear/toggle modes). A commit
// copies the shadow into the live value q in one atomic step, so every bit
// of a multi-bit field changes on the same edge.
//
// Parameters
//   WIDTH        data width, 1..256
//   RESET_VALUE  reset value of both q and shadow (WIDTH bits)
//   STRB_W       derived, ceil(WIDTH/8); not meant to be overridden
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous reset, active-high, overrides all other inputs
//   wr_valid     write request
//   wr_ready     write slot available (low during reset and the busy cycle)
//   wr_mode      00 write, 01 set, 10 clear, 11 toggle
//   wr_data      write operand
//   wr_strb      byte-lane enables, the top lane may be partial
//   commit       copy shadow (including a same-cycle write) into q
//   q            live value
//   shadow       shadow value
//   pending      registered (shadow != q)
//   commit_ack   one-cycle pulse the cycle after a commit takes effect
//   changed      one-cycle pulse the cycle after a commit alters q
//   dbg_state    current FSM state (0 = IDLE, 1 = HOLD)
//
// Handshake: a write transfers on a rising edge where wr_valid && wr_ready.
// wr_ready depends only on the FSM state and rst, never on wr_valid, and the
// requester may hold wr_valid/wr_mode/wr_data/wr_strb until it transfers.
// ---------------------------------------------------------------------------
module shadow_reset_reg #(
    parameter int unsigned            WIDTH       = 32,
    parameter logic [WIDTH-1:0]       RESET_VALUE = '0,
    localparam int unsigned           STRB_W      = (WIDTH + 7) / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [1:0]        wr_mode,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic              commit,
    output logic [WIDTH-1:0]  q,
    output logic [WIDTH-1:0]  shadow,
    output logic              pending,
    output logic              commit_ack,
    output logic              changed,
    output logic              dbg_state
);

    typedef enum logic {
        IDLE = 1'b0,   // write port open
        HOLD = 1'b1    // cycle after a commit, write port closed
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_shadow;
    logic             r_pending;
    logic             r_commit_ack;
    logic             r_changed;

    logic             w_ready;
    logic             w_accept;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_op;
    logic [WIDTH-1:0] w_shadow_nxt;
    logic [WIDTH-1:0] w_q_nxt;

    // ---------------------------------------------------------------------
    // FSM: next state. Any commit (also while in HOLD) re-arms HOLD.
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt = IDLE;
        if (commit) begin
            w_state_nxt = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    assign w_ready  = (r_state == IDLE) && !rst;
    assign w_accept = wr_valid && w_ready;

    // ---------------------------------------------------------------------
    // Shadow update: expand byte strobes to a per-bit mask, so a partial
    // top lane naturally covers only the bits that exist.
    // ---------------------------------------------------------------------
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            w_mask[i] = wr_strb[i / 8];
        end
    end

    always_comb begin
        w_op = wr_data;
        case (wr_mode)
            2'b00:   w_op = wr_data;
            2'b01:   w_op = r_shadow | wr_data;
            2'b10:   w_op = r_shadow & ~wr_data;
            default: w_op = r_shadow ^ wr_data;
        endcase
    end

    always_comb begin
        w_shadow_nxt = r_shadow;
        if (w_accept) begin
            w_shadow_nxt = (w_op & w_mask) | (r_shadow & ~w_mask);
        end
    end

    // Commit takes the post-write shadow, merging a same-cycle write.
    always_comb begin
        w_q_nxt = r_q;
        if (commit) begin
            w_q_nxt = w_shadow_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q          <= RESET_VALUE;
            r_shadow     <= RESET_VALUE;
            r_pending    <= 1'b0;
            r_commit_ack <= 1'b0;
            r_changed    <= 1'b0;
        end else begin
            r_q          <= w_q_nxt;
            r_shadow     <= w_shadow_nxt;
            r_pending    <= (w_shadow_nxt != w_q_nxt);
            r_commit_ack <= commit;
            r_changed    <= commit && (w_shadow_nxt != r_q);
        end
    end

    assign wr_ready   = w_ready;
    assign q          = r_q;
    assign shadow     = r_shadow;
    assign pending    = r_pending;
    assign commit_ack = r_commit_ack;
    assign changed    = r_changed;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_shadow_reset_reg.sv
module tb_shadow_reset_reg;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 32-bit instance
    logic        rst;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_mode;
    logic [31:0] wr_data;
    logic [3:0]  wr_strb;
    logic        commit;
    logic [31:0] q;
    logic [31:0] shadow;
    logic        pending;
    logic        commit_ack;
    logic        changed;
    logic        dbg_state;

    // 12-bit instance
    logic        s_rst;
    logic        s_wr_valid;
    logic        s_wr_ready;
    logic [1:0]  s_wr_mode;
    logic [11:0] s_wr_data;
    logic [1:0]  s_wr_strb;
    logic        s_commit;
    logic [11:0] s_q;
    logic [11:0] s_shadow;
    logic        s_pending;
    logic        s_commit_ack;
    logic        s_changed;
    logic        s_dbg_state;

    shadow_reset_reg #(
        .WIDTH       (32),
        .RESET_VALUE (32'hA5A5_0001)
    ) u_dut32 (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_mode    (wr_mode),
        .wr_data    (wr_data),
        .wr_strb    (wr_strb),
        .commit     (commit),
        .q          (q),
        .shadow     (shadow),
        .pending    (pending),
        .commit_ack (commit_ack),
        .changed    (changed),
        .dbg_state  (dbg_state)
    );

    shadow_reset_reg #(
        .WIDTH       (12),
        .RESET_VALUE (12'h123)
    ) u_dut12 (
        .clk        (clk),
        .rst        (s_rst),
        .wr_valid   (s_wr_valid),
        .wr_ready   (s_wr_ready),
        .wr_mode    (s_wr_mode),
        .wr_data    (s_wr_data),
        .wr_strb    (s_wr_strb),
        .commit     (s_commit),
        .q          (s_q),
        .shadow     (s_shadow),
        .pending    (s_pending),
        .commit_ack (s_commit_ack),
        .changed    (s_changed),
        .dbg_state  (s_dbg_state)
    );

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_wr(input logic v, input logic [1:0] m,
                            input logic [31:0] d, input logic [3:0] s,
                            input logic c);
        wr_valid = v;
        wr_mode  = m;
        wr_data  = d;
        wr_strb  = s;
        commit   = c;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        drive_wr(1'b1, 2'b00, 32'h5555_AAAA, 4'hF, 1'b1);
        s_rst = 1'b1;
        s_wr_valid = 1'b1;
        s_wr_mode  = 2'b00;
        s_wr_data  = 12'hFFF;
        s_wr_strb  = 2'b11;
        s_commit   = 1'b1;

        // Test 1: reset held 3 cycles with write and commit active
        #1;
        chk("rst_wr_ready_low", {31'd0, wr_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_q", q, 32'hA5A5_0001);
            chk("rst_shadow", shadow, 32'hA5A5_0001);
            chk("rst_no_ack", {31'd0, commit_ack}, 32'd0);
        end
        chk("rst_pending", {31'd0, pending}, 32'd0);
        chk("rst_changed", {31'd0, changed}, 32'd0);
        chk("rst12_q", {20'd0, s_q}, 32'h123);
        rst = 1'b0;
        drive_wr(1'b0, 2'b00, 32'h0, 4'h0, 1'b0);
        s_rst = 1'b0;
        s_wr_valid = 1'b0;
        s_commit   = 1'b0;
        #1;
        chk("post_rst_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("post_rst_state", {31'd0, dbg_state}, 32'd0);
        tick();
        chk("post_rst_no_ack", {31'd0, commit_ack}, 32'd0);
        chk("post_rst_q_kept", q, 32'hA5A5_0001);

        // Clear to 0 with write-through commit
        drive_wr(1'b1, 2'b00, 32'h0, 4'hF, 1'b1);
        tick();
        chk("clr_q", q, 32'h0);
        chk("clr_changed", {31'd0, changed}, 32'd1);
        chk("clr_state_hold", {31'd0, dbg_state}, 32'd1);
        drive_wr(1'b0, 2'b00, 32'h0, 4'h0, 1'b0);
        tick();

        // Test 2: strobed write then commit
        drive_wr(1'b1, 2'b00, 32'h1122_3344, 4'b0101, 1'b0);
        tick();
        chk("strb_shadow", shadow, 32'h0022_0044);
        chk("strb_pending", {31'd0, pending}, 32'd1);
        chk("strb_q_kept", q, 32'h0);
        drive_wr(1'b0, 2'b00, 32'h0, 4'h0, 1'b1);
        tick();
        chk("cm_q", q, 32'h0022_0044);
        chk("cm_ack", {31'd0, commit_ack}, 32'd1);
        chk("cm_changed", {31'd0, changed}, 32'd1);
        chk("cm_pending", {31'd0, pending}, 32'd0);
        chk("cm_wr_ready_low", {31'd0, wr_ready}, 32'd0);
        commit = 1'b0;
        tick();
        chk("cm_wr_ready_back", {31'd0, wr_ready}, 32'd1);
        chk("cm_ack_pulse", {31'd0, commit_ack}, 32'd0);
        chk("cm_changed_pulse", {31'd0, changed}, 32'd0);

        // Test 3: modes
        drive_wr(1'b1, 2'b00, 32'h00FF_00FF, 4'hF, 1'b0);
        tick();
        chk("mode_base", shadow, 32'h00FF_00FF);
        drive_wr(1'b1, 2'b01, 32'h0F00_0000, 4'hF, 1'b0);
        tick();
        chk("mode_set", shadow, 32'h0FFF_00FF);
        drive_wr(1'b1, 2'b10, 32'h0000_000F, 4'hF, 1'b0);
        tick();
        chk("mode_clear", shadow, 32'h0FFF_00F0);
        drive_wr(1'b1, 2'b11, 32'hFFFF_FFFF, 4'hF, 1'b0);
        tick();
        chk("mode_toggle", shadow, 32'hF000_FF0F);
        drive_wr(1'b1, 2'b11, 32'hFFFF_FFFF, 4'h0, 1'b0);
        tick();
        chk("strb_zero_noop", shadow, 32'hF000_FF0F);
        chk("mode_pending", {31'd0, pending}, 32'd1);

        // Test 4: write and commit in the same cycle
        drive_wr(1'b1, 2'b00, 32'hDEAD_BEEF, 4'hF, 1'b1);
        tick();
        chk("wt_q", q, 32'hDEAD_BEEF);
        chk("wt_pending", {31'd0, pending}, 32'd0);
        chk("wt_ack", {31'd0, commit_ack}, 32'd1);
        drive_wr(1'b1, 2'b00, 32'h1234_5678, 4'hF, 1'b0);
        tick();
        chk("wt_blocked_shadow", shadow, 32'hDEAD_BEEF);
        chk("wt_ready_back", {31'd0, wr_ready}, 32'd1);
        tick();
        chk("wt_accepted_shadow", shadow, 32'h1234_5678);
        chk("wt_accepted_pending", {31'd0, pending}, 32'd1);
        drive_wr(1'b0, 2'b00, 32'h0, 4'h0, 1'b1);
        tick();
        chk("sync_q", q, 32'h1234_5678);
        commit = 1'b0;
        tick();

        // Test 5: commits of an unchanged value, back to back
        commit = 1'b1;
        tick();
        chk("nc1_ack", {31'd0, commit_ack}, 32'd1);
        chk("nc1_changed", {31'd0, changed}, 32'd0);
        chk("nc1_wr_ready", {31'd0, wr_ready}, 32'd0);
        tick();
        chk("nc2_ack", {31'd0, commit_ack}, 32'd1);
        chk("nc2_changed", {31'd0, changed}, 32'd0);
        chk("nc2_wr_ready", {31'd0, wr_ready}, 32'd0);
        commit = 1'b0;
        tick();
        chk("nc_end_ack", {31'd0, commit_ack}, 32'd0);
        chk("nc_end_wr_ready", {31'd0, wr_ready}, 32'd1);
        chk("nc_q", q, 32'h1234_5678);

        // Test 6: 12-bit instance, partial top lane
        s_wr_valid = 1'b1;
        s_wr_mode  = 2'b00;
        s_wr_data  = 12'hABC;
        s_wr_strb  = 2'b10;
        tick();
        chk("w12_shadow", {20'd0, s_shadow}, 32'hA23);
        chk("w12_pending", {31'd0, s_pending}, 32'd1);
        chk("w12_q_kept", {20'd0, s_q}, 32'h123);
        s_wr_valid = 1'b0;
        s_commit   = 1'b1;
        tick();
        chk("c12_q", {20'd0, s_q}, 32'hA23);
        chk("c12_state_hold", {31'd0, s_dbg_state}, 32'd1);
        s_commit = 1'b0;
        s_rst    = 1'b1;
        tick();
        chk("r12_q", {20'd0, s_q}, 32'h123);
        chk("r12_shadow", {20'd0, s_shadow}, 32'h123);
        chk("r12_flags", {29'd0, s_pending, s_commit_ack, s_changed}, 32'd0);
        chk("r12_wr_ready", {31'd0, s_wr_ready}, 32'd0);
        chk("r12_state", {31'd0, s_dbg_state}, 32'd0);
        s_rst = 1'b0;
        #1;
        chk("r12_wr_ready_back", {31'd0, s_wr_ready}, 32'd1);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shadow_reset_reg.md
# shadow_reset_reg

Parametrised WIDTH-bit control register with a synchronous, active-high reset to RESET_VALUE. Writes go into a shadow copy through a valid/ready port that supports byte strobes and write/set/clear/toggle modes. A commit request copies the shadow into the live output in one atomic step. The block is used wherever a multi-bit configuration field has to change all at once, such as clock-divider, mask or mode registers behind a register-mapped bus.

## Interface
- WIDTH, 32, data width in bits; legal range 1..256.
- RESET_VALUE, 0, reset value of both the live copy and the shadow copy; truncated to WIDTH bits.
- STRB_W, derived, equals ceil(WIDTH/8); not overridable.
- clk  in  1  the single clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted when wr_valid && wr_ready.
- wr_mode  in  2  00 write, 01 set (OR), 10 clear (AND-NOT), 11 toggle (XOR).
- wr_data  in  WIDTH  write operand.
- wr_strb  in  STRB_W  byte-lane enables; the last lane covers WIDTH-8*(STRB_W-1) bits.
- commit  in  1  copy the shadow into the live copy (single-cycle pulse or level).
- q  out  WIDTH  live value.
- shadow  out  WIDTH  shadow value.
- pending  out  1  shadow differs from q.
- commit_ack  out  1  one-cycle pulse, the cycle after a commit takes effect.
- changed  out  1  one-cycle pulse, the cycle after a commit alters q.

## Operation
- **Reset.** While rst is high at a clk edge: q and shadow go to RESET_VALUE; pending, commit_ack and changed go to 0; the internal busy flag clears. rst overrides every other input in the same cycle. A write or commit presented during reset is dropped and never acked.
- **Write acceptance.** A write is accepted when wr_valid && wr_ready.
- **Write update.** For each byte lane with its strobe bit set, the new shadow lane is f(shadow lane, wr_data lane):
  - write: d
  - set: s|d
  - clear: s&~d
  - toggle: s^d
- **Lanes without strobe** keep their value. wr_strb = 0 is still accepted and is a no-op.
- **Commit.** On commit at an edge, q takes the shadow value that results after any write accepted in that same cycle. A simultaneous write is therefore merged into the commit (write-through).
- **Busy.** commit sets a one-cycle busy flag. wr_ready = !busy && !rst, so wr_ready is low for exactly the cycle after each commit cycle.
- **Back-to-back commits.** A commit arriving while busy is honoured: it re-copies the shadow, re-arms busy and raises commit_ack again.
- **pending.** Registered; equals (shadow != q) after the edge. pending goes to 0 in the cycle after any commit.
- **changed.** Registered; 1 when the committed value differs from the previous q.
- **States.** IDLE (busy=0) and HOLD (busy=1).
  - IDLE -> HOLD on commit.
  - HOLD -> HOLD on commit.
  - HOLD -> IDLE otherwise.
  - Any state -> IDLE on rst.

## Timing
- Write-to-shadow latency: 1 cycle. shadow shows the result at the edge that accepts the write.
- Commit-to-q latency: 1 cycle. commit_ack and changed are high during the cycle after that edge.
- wr_ready is combinational from busy and rst only, never from wr_valid.
- Throughput:
  - with no commits, 1 write per cycle;
  - a commit costs one write slot.
- Reset values:
  - q = shadow = RESET_VALUE;
  - wr_ready = 0 while rst is high, 1 from the first cycle after reset;
  - pending = commit_ack = changed = 0.

## Test plan
1. **Reset.** WIDTH=32, RESET_VALUE=0xA5A5_0001. Assert rst for 3 cycles with wr_valid=1 and commit=1, then release. Required: q = shadow = 0xA5A5_0001, no commit_ack pulse, wr_ready=1 in the first cycle after release.
2. **Strobed write, then commit.** Write 0x1122_3344 with wr_strb=0b0101, mode 00, onto 0. Required: shadow = 0x0022_0044, pending=1, q unchanged. Then commit. Required: q = 0x0022_0044, commit_ack=1, changed=1, pending=0, wr_ready=0 for one cycle.
3. **Modes.** Start from shadow = 0x00FF_00FF with full strobes. Apply set 0x0F00_0000, then clear 0x0000_000F, then toggle 0xFFFF_FFFF. Required: shadow = 0xF000_FF0F.
4. **Write and commit in the same cycle.** Present write 0xDEAD_BEEF together with commit. Required: q = 0xDEAD_BEEF at the next cycle, pending=0. A write held valid in the following cycle is not accepted until wr_ready returns.
5. **Commit of an unchanged value.** Commit when shadow == q. Required: commit_ack=1, changed=0. Two consecutive commit cycles give two commit_ack pulses and hold wr_ready low for 2 cycles.
6. **Odd width.** WIDTH=12, wr_strb=0b10, data 0xABC. Required: shadow[11:8]=0xA, shadow[7:0] kept. Then assert rst in the middle of the busy cycle. Required: all outputs return to their reset values at that edge.
